// File: rtl/cpu_pkg.sv
// Shared CPU definitions: HI/LO unit op encodings and default busy durations,
// also used by the decoder and the hazard unit.
package cpu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: fixed-latency busy counter, result computed from
// latched operands and committed on the last busy edge. MULT_DIV_MADD_EN enables ops 6-9.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  logic [4:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;

  logic        w_op_legal, w_accept, w_busy, w_last, w_sgn, w_wr;
  logic [63:0] w_ext_a, w_ext_b, w_prod, w_res;
  logic        w_neg_a, w_neg_b, w_div_zero;
  logic [31:0] w_mag_a, w_mag_b, w_den, w_uq, w_ur, w_quo, w_rem;

  always_comb begin
    w_op_legal = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: w_op_legal = 1'b1;
`ifdef MULT_DIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_op_legal = 1'b1;
`endif
      default: w_op_legal = 1'b0;
    endcase
  end

  assign w_busy   = (r_cnt != 5'd0);
  assign w_last   = (r_cnt == 5'd1);
  assign w_accept = start & ~flush & ~w_busy & w_op_legal;

  // One 64x64 multiplier serves both signednesses: the low 64 bits of the
  // extended product are the correct signed or unsigned 64-bit result.
  assign w_sgn   = op_is_signed(r_op);
  assign w_ext_a = w_sgn ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_ext_b = w_sgn ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_neg_a    = w_sgn & r_a[31];
  assign w_neg_b    = w_sgn & r_b[31];
  assign w_mag_a    = w_neg_a ? (~r_a + 32'd1) : r_a;
  assign w_mag_b    = w_neg_b ? (~r_b + 32'd1) : r_b;
  assign w_div_zero = (r_b == 32'd0);
  assign w_den      = w_div_zero ? 32'd1 : w_mag_b;
  assign w_uq       = w_mag_a / w_den;
  assign w_ur       = w_mag_a % w_den;
  assign w_quo      = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
  assign w_rem      = w_neg_a ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    w_res = {r_hi, r_lo};
    w_wr  = 1'b0;
    case (r_op)
      OP_MULT, OP_MULTU: begin
        w_res = w_prod;
        w_wr  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        w_res = {w_rem, w_quo};
        w_wr  = ~w_div_zero;
      end
`ifdef MULT_DIV_MADD_EN
      OP_MADD, OP_MADDU: begin
        w_res = {r_hi, r_lo} + w_prod;
        w_wr  = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        w_res = {r_hi, r_lo} - w_prod;
        w_wr  = 1'b1;
      end
`endif
      default: w_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 5'd0;
      r_op  <= 4'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else if (w_accept) begin
      r_op <= op;
      r_a  <= src_a;
      r_b  <= src_b;
      if (op == OP_MTHI)      r_hi  <= src_a;
      else if (op == OP_MTLO) r_lo  <= src_a;
      else                    r_cnt <= op_is_div(op) ? DIV_CNT : MULT_CNT;
    end else if (w_busy) begin
      r_cnt <= r_cnt - 5'd1;
      if (w_last && w_wr) {r_hi, r_lo} <= w_res;
    end
  end

  assign busy = w_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO/busy-length,
// a negedge monitor checks on each busy fall and on queued immediate checks.
module tb_mult_div_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src_a = 32'd0, src_b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;   // busy length for completions, busy level for immediate checks
  } exp_t;

  exp_t q_busy[$];
  exp_t q_now[$];
  int   n_tests = 0, n_fail = 0;
  int   run = 0;
  bit   prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: completion checks on busy falling, then any immediate checks.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      run++;
    end else begin
      if (prev_busy) begin
        if (q_busy.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got busy run %0d expected none", run);
        end else begin
          e = q_busy.pop_front();
          check({e.name, "_hi"}, hi, e.hi);
          check({e.name, "_lo"}, lo, e.lo);
          check({e.name, "_len"}, 32'(run), 32'(e.n));
        end
      end
      run = 0;
    end
    prev_busy = (busy === 1'b1);
    while (q_now.size() > 0) begin
      e = q_now.pop_front();
      check({e.name, "_hi"}, hi, e.hi);
      check({e.name, "_lo"}, lo, e.lo);
      check({e.name, "_busy"}, {31'd0, busy}, 32'(e.n));
    end
  end

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic expect_busy(input string name, input logic [31:0] h, input logic [31:0] l,
                             input int n);
    exp_t e;
    e = '{name: name, hi: h, lo: l, n: n};
    q_busy.push_back(e);
  endtask

  task automatic expect_now(input string name, input logic [31:0] h, input logic [31:0] l,
                            input int b);
    exp_t e;
    e = '{name: name, hi: h, lo: l, n: b};
    q_now.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (q_busy.size() != 0 && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    if (q_busy.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending completions expected 0", name, q_busy.size());
      q_busy.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    expect_now("reset", 32'h0, 32'h0, 0);

    expect_busy("mult", 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    drive(OP_MULT, 32'hFFFFFFFF, 32'h2, 1'b0);
    wait_idle("mult");
    expect_busy("multu", 32'h00000001, 32'hFFFFFFFE, 5);
    drive(OP_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0);
    wait_idle("multu");

    expect_busy("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    drive(OP_DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
    wait_idle("div_neg");
    expect_busy("divu_zero", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    drive(OP_DIVU, 32'h7, 32'h0, 1'b0);
    wait_idle("divu_zero");
    expect_busy("div_negb", 32'h00000001, 32'hFFFFFFFD, 10);
    drive(OP_DIV, 32'h7, 32'hFFFFFFFE, 1'b0);
    wait_idle("div_negb");
    expect_busy("div_ovf", 32'h0, 32'h80000000, 10);
    drive(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle("div_ovf");
    expect_busy("divu", 32'hF, 32'h0FFFFFFF, 10);
    drive(OP_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0);
    wait_idle("divu");

    drive(OP_MTHI, 32'h1234, 32'h0, 1'b0);
    expect_now("mthi", 32'h1234, 32'h0FFFFFFF, 0);

    // -3 * -4 = 12; an MTLO offered mid-flight must be dropped
    expect_busy("mult_negneg", 32'h0, 32'hC, 5);
    drive(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFC, 1'b0);
    drive(OP_MTLO, 32'hDEAD, 32'h0, 1'b0);
    expect_now("mtlo_busy", 32'h1234, 32'h0FFFFFFF, 1);
    wait_idle("mult_negneg");

    // start in the final busy cycle is ignored
    expect_busy("mult_last", 32'h0, 32'h1E, 5);
    drive(OP_MULT, 32'h5, 32'h6, 1'b0);
    repeat (4) @(negedge clk);
    drive(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    expect_now("last_ign", 32'h0, 32'h1E, 0);
    wait_idle("mult_last");
    repeat (3) @(negedge clk);
    expect_now("last_ign_idle", 32'h0, 32'h1E, 0);

    drive(OP_MULT, 32'h7, 32'h7, 1'b1);
    expect_now("flush_start", 32'h0, 32'h1E, 0);
    repeat (8) @(negedge clk);
    expect_now("flush_start_late", 32'h0, 32'h1E, 0);

    expect_busy("flush_busy", 32'h1, 32'h0, 5);
    drive(OP_MULTU, 32'h10000, 32'h10000, 1'b0);
    repeat (2) @(negedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle("flush_busy");

    // reset in busy cycle 2 aborts the divide
    expect_busy("div_reset", 32'h0, 32'h0, 2);
    drive(OP_DIV, 32'h100, 32'h3, 1'b0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_idle("div_reset");
    repeat (12) @(negedge clk);
    expect_now("div_reset_late", 32'h0, 32'h0, 0);

    drive(OP_MTHI, 32'h0, 32'h0, 1'b0);
    drive(OP_MTLO, 32'hFFFFFFFF, 32'h0, 1'b0);
    expect_now("madd_setup", 32'h0, 32'hFFFFFFFF, 0);
`ifdef MULT_DIV_MADD_EN
    expect_busy("maddu", 32'h1, 32'h0, 5);
    drive(OP_MADDU, 32'h1, 32'h1, 1'b0);
    wait_idle("maddu");
    expect_busy("msub", 32'h0, 32'hFFFFFFFF, 5);
    drive(OP_MSUB, 32'h1, 32'h1, 1'b0);
    wait_idle("msub");
`else
    drive(OP_MADDU, 32'h1, 32'h1, 1'b0);
    expect_now("maddu_off", 32'h0, 32'hFFFFFFFF, 0);
    repeat (8) @(negedge clk);
    expect_now("maddu_off_late", 32'h0, 32'hFFFFFFFF, 0);
`endif

    // reset wins over a same-cycle start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = OP_MULT; src_a = 32'h3; src_b = 32'h3;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    expect_now("reset_start", 32'h0, 32'h0, 0);
    repeat (8) @(negedge clk);
    expect_now("reset_start_late", 32'h0, 32'h0, 0);

    repeat (2) @(negedge clk);
    #1;
    if (q_busy.size() != 0 || q_now.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q_busy.size() + q_now.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
